// File: rtl/sensor_mon_pkg.sv
// Shared types, constants and the error rule for the sensor monitor.
package sensor_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int NUM_SENSORS = 4;

    function automatic logic sensor_err(input logic [3:0] f);
        return f[0] | (f[1] & f[2]) | (f[1] & f[3]);
    endfunction

endpackage

// File: rtl/sensor_monitor_if.sv
// Host-side bundle of the sensor monitor; fault_count exists only with SENSOR_MON_FAULT_CNT_EN.
interface sensor_monitor_if
    import sensor_mon_pkg::*;
#(
    parameter int CNT_WIDTH = 8
);
    logic                   enable;
    logic [NUM_SENSORS-1:0] sensors;
    logic                   ack;
    logic                   sample_strobe;
    logic [NUM_SENSORS-1:0] sensors_filt;
    logic                   error;
    logic                   alarm;
`ifdef SENSOR_MON_FAULT_CNT_EN
    logic [CNT_WIDTH-1:0]   fault_count;
`endif

    modport master (
        output enable, sensors, ack,
        input  sample_strobe, sensors_filt, error, alarm
`ifdef SENSOR_MON_FAULT_CNT_EN
        , input fault_count
`endif
    );

    modport slave (
        input  enable, sensors, ack,
        output sample_strobe, sensors_filt, error, alarm
`ifdef SENSOR_MON_FAULT_CNT_EN
        , output fault_count
`endif
    );
endinterface

// File: rtl/sensor_debounce.sv
// Single-bit strobe-qualified debouncer; srst holds the filter and counter at 0.
module sensor_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic srst,
    input  logic strobe,
    input  logic raw,
    output logic filt
);
    logic [3:0] cnt_r;
    logic       filt_r;
    logic [3:0] cnt_inc_s;

    assign cnt_inc_s = cnt_r + 4'd1;
    assign filt      = filt_r;

    // Count consecutive disagreeing strobes; flip the filter once the run reaches DEBOUNCE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r  <= 4'd0;
            filt_r <= 1'b0;
        end else if (srst) begin
            cnt_r  <= 4'd0;
            filt_r <= 1'b0;
        end else if (strobe) begin
            if (raw != filt_r) begin
                if (cnt_inc_s == 4'(DEBOUNCE)) begin
                    filt_r <= ~filt_r;
                    cnt_r  <= 4'd0;
                end else begin
                    cnt_r  <= cnt_inc_s;
                end
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end
endmodule

// File: rtl/sensor_monitor.sv
// Sensor scan controller: sample divider, per-bit debounce, alarm/ack FSM.
// Optional saturating alarm counter enabled by SENSOR_MON_FAULT_CNT_EN.
module sensor_monitor
    import sensor_mon_pkg::*;
#(
    parameter int SAMPLE_DIV = 10,
    parameter int DEBOUNCE   = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic            clk,
    input  logic            n_rst,
    sensor_monitor_if.slave bus
);
    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [DIV_W-1:0]       div_r;
    logic [DIV_W-1:0]       div_next_s;
    logic                   strobe_r;
    logic                   alarm_r;
    logic                   clear_s;
    logic                   error_s;
    logic [NUM_SENSORS-1:0] filt_s;

    // A disable takes effect on the very next edge, so clear on the input level as well as in IDLE.
    assign clear_s = ~bus.enable | (state_r == IDLE);
    assign error_s = sensor_err(filt_s);

    // Divider wrap arithmetic.
    always_comb begin
        div_next_s = div_r;
        if (div_r == DIV_LAST) begin
            div_next_s = {DIV_W{1'b0}};
        end else begin
            div_next_s = div_r + DIV_W'(1);
        end
    end

    // Divider and registered strobe; strobe is high exactly while the divider sits at its last value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_r    <= {DIV_W{1'b0}};
            strobe_r <= 1'b0;
        end else if (clear_s) begin
            div_r    <= {DIV_W{1'b0}};
            strobe_r <= 1'b0;
        end else begin
            div_r    <= div_next_s;
            strobe_r <= (div_next_s == DIV_LAST);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_deb
            sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
                .clk    (clk),
                .n_rst  (n_rst),
                .srst   (clear_s),
                .strobe (strobe_r),
                .raw    (bus.sensors[gi]),
                .filt   (filt_s[gi])
            );
        end
    endgenerate

    // Next-state logic; enable low overrides everything, including a same-cycle ack.
    always_comb begin
        state_next_s = state_r;
        if (!bus.enable) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = MONITOR;
                MONITOR: state_next_s = error_s ? ALARM : MONITOR;
                ALARM: begin
                    if (bus.ack) begin
                        state_next_s = error_s ? HOLD : MONITOR;
                    end else begin
                        state_next_s = ALARM;
                    end
                end
                HOLD:    state_next_s = error_s ? HOLD : MONITOR;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register with alarm registered from the next state so it tracks ALARM exactly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            alarm_r <= (state_next_s == ALARM);
        end
    end

    assign bus.sample_strobe = strobe_r;
    assign bus.sensors_filt  = filt_s;
    assign bus.error         = error_s;
    assign bus.alarm         = alarm_r;

`ifdef SENSOR_MON_FAULT_CNT_EN
    logic [CNT_WIDTH-1:0] fault_r;

    // Saturating count of raised alarms; survives disable, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fault_r <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == MONITOR) && (state_next_s == ALARM) &&
                     (fault_r != {CNT_WIDTH{1'b1}})) begin
            fault_r <= fault_r + CNT_WIDTH'(1);
        end
    end

    assign bus.fault_count = fault_r;
`endif
endmodule
